// File: rtl/main_mem_burst.sv
// main_mem_burst: byte-serial main memory behind the cache refill/write-back link.
// Moves one 4-byte block per request over a shared bidirectional byte bus.
//
// Request handshake: a request (rd_mem or wr_mem high) is taken only on a rising
// edge where the block is in IDLE with ready_mem high; wr_mem has priority over
// rd_mem when both are high. In every other state, rd_mem and wr_mem are ignored.
// ready_mem falls on the accepting edge. For a write it rises on the commit edge.
// For a read it rises on the edge that starts the 4-beat burst.
module main_mem_burst #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 8,
    parameter int BLOCKSIZE = 4,
    parameter int MEMBITS   = 10,
    parameter int LATENCY   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AWIDTH-1:0] addr_mem,
    inout  wire  [DWIDTH-1:0] data_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    output logic              ready_mem
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WCAP   = 3'd1,
        WLAT   = 3'd2,
        RLAT   = 3'd3,
        RREADY = 3'd4,
        RBURST = 3'd5
    } state_t;

    localparam logic [7:0] LAT_M1    = 8'(LATENCY - 1);
    localparam logic [1:0] LAST_BEAT = 2'(BLOCKSIZE - 1);

    state_t                       state_q, state_d;
    logic [7:0]                   lat_q;
    logic [1:0]                   beat_q;
    logic [MEMBITS-3:0]           base_q;
    logic [3:0][DWIDTH-1:0]       buf_q;
    logic                         ready_q, ready_d;
    logic                         oe_q, oe_d;
    logic [DWIDTH-1:0]            data_q, data_d;
    logic [DWIDTH-1:0]            mem [0:(1<<MEMBITS)-1];

    // Offset bits and aliasing upper bits of the address are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{addr_mem[AWIDTH-1:MEMBITS], addr_mem[1:0]};

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_mem) state_d = WCAP;
                     else if (rd_mem) state_d = RLAT;
            WCAP:    if (beat_q == LAST_BEAT) state_d = WLAT;
            WLAT:    if (lat_q == 8'd0) state_d = IDLE;
            RLAT:    if (lat_q == 8'd0) state_d = RREADY;
            RREADY:  state_d = RBURST;
            RBURST:  if (beat_q == LAST_BEAT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every output leaves a flop.
    always_comb begin
        ready_d = (state_d == IDLE) || (state_d == RBURST);
        oe_d    = (state_d == RBURST);
        data_d  = data_q;
        if (state_d == RBURST)
            data_d = buf_q[(state_q == RBURST) ? beat_q + 2'd1 : 2'd0];
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b1;
            oe_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
        end
    end

    // Counters, block base and the 4-byte staging buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_q  <= '0;
            beat_q <= '0;
            base_q <= '0;
            buf_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_mem || rd_mem) begin
                        base_q <= addr_mem[MEMBITS-1:2];
                        lat_q  <= LAT_M1;
                        beat_q <= 2'd0;
                    end
                end
                WCAP: begin
                    buf_q[beat_q] <= data_mem;
                    beat_q        <= beat_q + 2'd1;
                    if (beat_q == LAST_BEAT) lat_q <= LAT_M1;
                end
                WLAT: begin
                    if (lat_q != 8'd0) lat_q <= lat_q - 8'd1;
                end
                RLAT: begin
                    if (lat_q != 8'd0) begin
                        lat_q <= lat_q - 8'd1;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            buf_q[k] <= mem[{base_q, k[1:0]}];
                    end
                end
                RREADY: begin
                    beat_q <= 2'd0;
                end
                RBURST: begin
                    beat_q <= beat_q + 2'd1;
                end
                default: begin
                    lat_q  <= '0;
                    beat_q <= '0;
                    base_q <= '0;
                    buf_q  <= '0;
                end
            endcase
        end
    end

    // Array commit: all four bytes land together on the final latency edge.
    always_ff @(posedge clock) begin
        if (state_q == WLAT && lat_q == 8'd0) begin
            for (int k = 0; k < 4; k++)
                mem[{base_q, k[1:0]}] <= buf_q[k];
        end
    end

    assign ready_mem = ready_q;
    assign data_mem  = oe_q ? data_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_main_mem_burst.sv
// tb_main_mem_burst: directed scenarios against a transaction-level timing model.
module tb_main_mem_burst;

    localparam int LAT = 4;

    logic        clock;
    logic        reset;
    logic [15:0] addr_mem;
    logic        rd_mem;
    logic        wr_mem;
    wire  [7:0]  data_mem;
    logic        ready_mem;

    logic        tb_oe;
    logic [7:0]  tb_drv;

    assign data_mem = tb_oe ? tb_drv : 8'hzz;

    int n_checks = 0;
    int n_err    = 0;

    main_mem_burst #(
        .AWIDTH(16), .DWIDTH(8), .BLOCKSIZE(4), .MEMBITS(10), .LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .addr_mem(addr_mem),
        .data_mem(data_mem),
        .rd_mem(rd_mem),
        .wr_mem(wr_mem),
        .ready_mem(ready_mem)
    );

    // Clock: posedges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus released: reads as Z (4-state) or 0 (2-state resolution).
    task automatic check_undriven(input string name);
        n_checks++;
        if (!(data_mem === 8'hzz || data_mem === 8'h00)) begin
            n_err++;
            $display("FAIL %s: bus driven with %0h expected released", name, data_mem);
        end
    endtask

    // ---------------- model ----------------
    // Transaction timeline: a request accepted on edge E0 owns the block until
    // E0+LAT+5 (read) or E0+4+LAT (write). Edges are numbered since reset release.
    int          cyc;
    int          t_kind;      // 0 none, 1 read, 2 write
    int          t_e0;
    logic [7:0]  t_base;
    logic [7:0]  wbuf [4];
    logic [7:0]  mdl_mem [0:1023];
    logic [7:0]  exp_q [$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            t_kind <= 0;
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (t_kind == 0) begin
                if (wr_mem || rd_mem) begin
                    t_kind <= wr_mem ? 2 : 1;
                    t_e0   <= cyc + 1;
                    t_base <= addr_mem[9:2];
                end
            end else if (t_kind == 2) begin
                if (cyc + 1 - t_e0 >= 1 && cyc + 1 - t_e0 <= 4)
                    wbuf[cyc - t_e0] <= tb_drv;
                if (cyc + 1 == t_e0 + 4 + LAT) begin
                    for (int k = 0; k < 4; k++)
                        mdl_mem[{t_base, k[1:0]}] <= wbuf[k];
                    t_kind <= 0;
                end
            end else begin
                if (cyc + 1 == t_e0 + LAT)
                    for (int k = 0; k < 4; k++)
                        exp_q.push_back(mdl_mem[{t_base, k[1:0]}]);
                if (cyc + 1 == t_e0 + LAT + 5)
                    t_kind <= 0;
            end
        end
    end

    // Per-cycle compare, 2 time units after each rising edge.
    logic       exp_ready;
    logic [7:0] exp_beat;
    always begin
        @(posedge clock);
        #2;
        exp_ready = !((t_kind == 1 && cyc <= t_e0 + LAT) || t_kind == 2);
        check("ready_cycle", {31'd0, ready_mem}, {31'd0, exp_ready});
        if (tb_oe) begin
            check("bus_write_beat", {24'd0, data_mem}, {24'd0, tb_drv});
        end else if (t_kind == 1 && cyc >= t_e0 + LAT + 1 && cyc <= t_e0 + LAT + 4) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL beat_cycle: got %0h expected none queued", data_mem);
            end else begin
                exp_beat = exp_q.pop_front();
                check("beat_cycle", {24'd0, data_mem}, {24'd0, exp_beat});
            end
        end else begin
            check_undriven("bus_idle");
        end
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [15:0] addr, input logic [31:0] beats,
                            input bit both, input int abort_i, output int low);
        low = 0;
        @(negedge clock);
        addr_mem = addr; wr_mem = 1'b1; rd_mem = both;
        for (int i = 0; i <= LAT + 4; i++) begin
            @(negedge clock);
            if (i == 0) begin wr_mem = 1'b0; rd_mem = 1'b0; end
            if (!ready_mem) low++;
            if (i < 4) begin tb_oe = 1'b1; tb_drv = beats[8*i +: 8]; end
            else tb_oe = 1'b0;
            if (i == abort_i) begin
                #2 reset = 1'b1;
                #1 check("rst_ready_now", {31'd0, ready_mem}, 32'd1);
                check_undriven("rst_bus_now");
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input bit noise,
                           output logic [3:0][7:0] got, output int low);
        low = 0;
        got = '0;
        @(negedge clock);
        addr_mem = addr; rd_mem = 1'b1;
        for (int i = 0; i <= LAT + 4; i++) begin
            @(negedge clock);
            rd_mem = 1'b0; wr_mem = 1'b0;
            if (noise && i >= 1 && i <= LAT + 3) begin
                rd_mem = 1'b1; wr_mem = 1'b1;
                addr_mem = 16'($urandom_range(0, 16'hffff));
            end
            if (!ready_mem) low++;
            if (i >= LAT + 1) got[i-LAT-1] = data_mem;
        end
    endtask

    task automatic check_beats(input string name, input logic [3:0][7:0] got,
                               input logic [31:0] exp);
        for (int k = 0; k < 4; k++)
            check(name, {24'd0, got[k]}, {24'd0, exp[8*k +: 8]});
    endtask

    // ---------------- scenarios ----------------
    logic [3:0][7:0] got;
    int              low;

    initial begin
        reset = 1'b1; rd_mem = 1'b0; wr_mem = 1'b0; addr_mem = '0;
        tb_oe = 1'b0; tb_drv = '0;
        repeat (3) @(negedge clock);
        check("reset_ready", {31'd0, ready_mem}, 32'd1);
        check_undriven("reset_bus");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("idle_ready", {31'd0, ready_mem}, 32'd1);

        do_write(16'h0123, 32'hD4C3B2A1, 1'b0, -1, low);
        check("write_low_cycles", low, 32'd8);
        do_read(16'h0122, 1'b0, got, low);
        check("read_low_cycles", low, 32'd5);
        check_beats("read_0122", got, 32'hD4C3B2A1);

        do_write(16'h0420, 32'h44332211, 1'b0, -1, low);
        do_read(16'h0020, 1'b0, got, low);
        check_beats("alias_0020", got, 32'h44332211);

        do_write(16'h0040, 32'h58575655, 1'b1, -1, low);
        check("both_low_cycles", low, 32'd8);
        do_read(16'h0040, 1'b0, got, low);
        check_beats("both_then_read", got, 32'h58575655);

        do_write(16'h0080, 32'h04030201, 1'b0, -1, low);
        do_write(16'h0080, 32'hF3F2F1F0, 1'b0, 6, low);
        repeat (2) @(negedge clock);
        check("post_reset_ready", {31'd0, ready_mem}, 32'd1);
        do_read(16'h0080, 1'b0, got, low);
        check_beats("abort_keeps_old", got, 32'h04030201);

        do_read(16'h0121, 1'b1, got, low);
        check("noise_low_cycles", low, 32'd5);
        check_beats("noise_read", got, 32'hD4C3B2A1);

        repeat (6) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
